// File: rtl/s4ga_cfg_tx.sv
// s4ga_cfg_tx: streams a per-LUT config store (K indices + mask per LUT) to an S4GA fabric as SI_W-bit segments
// Ports: clk, rst (sync, active-high); run requests streaming; wr_en/wr_lut/wr_field/wr_data write one
// store field (wr_field==K selects the mask); si carries segments, fpga_rst holds the fabric in reset,
// frame_done pulses with the last segment of a pass, busy is high outside IDLE. All outputs registered.
module s4ga_cfg_tx #(
  parameter int N = 71,
  parameter int K = 5,
  parameter int SI_W = 4,
  parameter int RST_CYC = 72,
  localparam int N_W = $clog2(N),
  localparam int K_W = $clog2(K + 1),
  localparam int MASK_W = 2 ** K,
  localparam int MAX_W = MASK_W > N_W ? MASK_W : N_W,
  localparam int IDX_SEGS = (N_W + SI_W - 1) / SI_W,
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             wr_en,
  input  logic [N_W-1:0]   wr_lut,
  input  logic [K_W-1:0]   wr_field,
  input  logic [MAX_W-1:0] wr_data,
  output logic [SI_W-1:0]  si,
  output logic             fpga_rst,
  output logic             frame_done,
  output logic             busy
);
  localparam int MS = IDX_SEGS > MASK_SEGS ? IDX_SEGS : MASK_SEGS;
  localparam int PW = MS * SI_W;
  localparam int SG_W = $clog2(MS + 1);
  localparam int RC_W = $clog2(RST_CYC + 1);
  typedef enum logic [1:0] {IDLE, RESET, STREAM, DRAIN} state_t;
  logic [MAX_W-1:0] mem [N][K+1];
  state_t st, st_n;
  logic [N_W-1:0] lut, lut_n;
  logic [K_W-1:0] fld, fld_n;
  logic [SG_W-1:0] seg, seg_n, last, last_n;
  logic [RC_W-1:0] rc, rc_n;
  logic [PW-1:0] cur, fv;
  logic end_pass, rc_done, adv, strm, done_n;
  int sh;
  always_comb begin
    last = fld == K_W'(K) ? SG_W'(MASK_SEGS - 1) : SG_W'(IDX_SEGS - 1);
    end_pass = lut == N_W'(N - 1) && fld == K_W'(K) && seg == last;
    rc_done = rc == RC_W'(RST_CYC - 1);
    rc_n = st == RESET && run && !rc_done ? rc + 1'b1 : '0;
    st_n = st == IDLE ? (run ? RESET : IDLE)
         : st == RESET ? (!run ? IDLE : rc_done ? STREAM : RESET)
         : run ? STREAM : end_pass ? IDLE : DRAIN;
    adv = st == STREAM || st == DRAIN;
    strm = st_n == STREAM || st_n == DRAIN;
    seg_n = !adv || seg == last ? '0 : seg + 1'b1;
    fld_n = !adv ? '0 : seg != last ? fld : fld == K_W'(K) ? '0 : fld + 1'b1;
    lut_n = !adv ? '0 : seg != last || fld != K_W'(K) ? lut : end_pass ? '0 : lut + 1'b1;
    last_n = fld_n == K_W'(K) ? SG_W'(MASK_SEGS - 1) : SG_W'(IDX_SEGS - 1);
    done_n = strm && lut_n == N_W'(N - 1) && fld_n == K_W'(K) && seg_n == last_n;
    // a field is captured on its first segment, so later writes only affect its next read
    fv = seg_n == '0 ? PW'(mem[lut_n][fld_n]) : cur;
    sh = (int'(last_n) - int'(seg_n)) * SI_W;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      lut <= '0;
      fld <= '0;
      seg <= '0;
      rc <= '0;
      cur <= '0;
      si <= '0;
      fpga_rst <= 1'b1;
      frame_done <= 1'b0;
      busy <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j <= K; j++)
          mem[i][j] <= '0;
    end else begin
      st <= st_n;
      lut <= lut_n;
      fld <= fld_n;
      seg <= seg_n;
      rc <= rc_n;
      cur <= fv;
      si <= strm ? SI_W'(fv >> sh) : '0;
      fpga_rst <= !strm;
      frame_done <= done_n;
      busy <= st_n != IDLE;
      if (wr_en && int'(wr_lut) < N && int'(wr_field) <= K)
        mem[wr_lut][wr_field] <= wr_field == K_W'(K) ? wr_data : MAX_W'(wr_data[N_W-1:0]);
    end
  end
endmodule

// File: tb/tb_s4ga_cfg_tx.sv
// tb_s4ga_cfg_tx: randomized self-checking bench for s4ga_cfg_tx against a pass/field/segment reference model
module tb_s4ga_cfg_tx;
  localparam int N = 71, K = 5, SI_W = 4, RST_CYC = 72;
  localparam int IDX_SEGS = 2, MASK_SEGS = 8, LL = K * IDX_SEGS + MASK_SEGS, PASS = N * LL;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, wr_en = 1'b0;
  logic [6:0] wr_lut = '0;
  logic [2:0] wr_field = '0;
  logic [31:0] wr_data = '0;
  logic [3:0] si;
  logic fpga_rst, frame_done, busy;
  int n_cmp = 0, n_bad = 0, pos = 0;
  logic [31:0] ms [N][K+1];
  logic [31:0] rx [N][K+1];
  logic [31:0] mcur;
  bit v [N], nv [N];

  always #5 clk = ~clk;

  s4ga_cfg_tx dut (.clk(clk), .rst(rst), .run(run), .wr_en(wr_en), .wr_lut(wr_lut), .wr_field(wr_field),
                   .wr_data(wr_data), .si(si), .fpga_rst(fpga_rst), .frame_done(frame_done), .busy(busy));

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic void decode(input int p, output int l, output int f, output int s, output int last);
    int r;
    r = p % LL;
    l = p / LL;
    if (r < K * IDX_SEGS) begin
      f = r / IDX_SEGS;
      s = r % IDX_SEGS;
      last = IDX_SEGS - 1;
    end else begin
      f = K;
      s = r - K * IDX_SEGS;
      last = MASK_SEGS - 1;
    end
  endfunction

  task automatic model_write(input int l, input int f, input logic [31:0] d);
    if (l < N && f <= K) ms[l][f] = f == K ? d : d & 32'h7f;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j <= K; j++)
        ms[i][j] = '0;
  endtask

  task automatic cfg_write(input int l, input int f, input logic [31:0] d);
    wr_en = 1'b1;
    wr_lut = 7'(l);
    wr_field = 3'(f);
    wr_data = d;
    model_write(l, f, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_stream();
    int cnt;
    cnt = 0;
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!fpga_rst) break;
      if (busy) cnt++;
    end
    pos = 0;
    n_cmp++;
    if (cnt != RST_CYC || fpga_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_len got %0d cycles (fpga_rst=%b) exp %0d then stream", cnt, fpga_rst, RST_CYC);
    end
  endtask

  task automatic check_stream(input int ncyc, input int drop_at, input int raise_at, input bit rnd,
                              input int w3_at, input logic [31:0] w3_val);
    for (int c = 0; c < ncyc; c++) begin
      int l, f, s, last, wl, wf;
      logic [3:0] e;
      logic [31:0] wd;
      decode(pos, l, f, s, last);
      if (s == 0) mcur = ms[l][f];
      e = 4'(mcur >> ((last - s) * SI_W));
      n_cmp++;
      if (si !== e || fpga_rst !== 1'b0) begin
        n_bad++;
        $display("FAIL stream p=%0d lut=%0d field=%0d seg=%0d got si=%h rst=%b exp si=%h rst=0", pos, l, f, s, si, fpga_rst, e);
      end
      n_cmp++;
      if (frame_done !== (pos == PASS - 1)) begin
        n_bad++;
        $display("FAIL frame_done p=%0d got %b exp %b", pos, frame_done, pos == PASS - 1);
      end
      wr_en = 1'b0;
      if (c == drop_at) run = 1'b0;
      if (c == raise_at) run = 1'b1;
      if (c == w3_at) begin
        wr_en = 1'b1;
        wr_lut = 7'd3;
        wr_field = 3'(K);
        wr_data = w3_val;
        model_write(3, K, w3_val);
      end else if (rnd && s != last && $urandom_range(0, 7) == 0) begin
        wl = int'($urandom_range(0, 80));
        wf = int'($urandom_range(0, 7));
        wd = $urandom;
        wr_en = 1'b1;
        wr_lut = 7'(wl);
        wr_field = 3'(wf);
        wr_data = wd;
        model_write(wl, wf, wd);
      end
      @(negedge clk);
      pos = (pos + 1) % PASS;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fpga_rst, si, frame_done, busy} !== 7'b1_0000_0_0) begin
      n_bad++;
      $display("FAIL reset_state got rst=%b si=%h fd=%b busy=%b exp 1/0/0/0", fpga_rst, si, frame_done, busy);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_stream();
    for (int l = 0; l < N; l++)
      for (int f = 0; f <= K; f++)
        cfg_write(l, f, $urandom);
    cfg_write(0, 0, 32'h55);
    cfg_write(0, 1, 32'h0);
    cfg_write(0, K, 32'hDEADBEEF);
    cfg_write(75, 0, 32'h7f);
    cfg_write(0, 6, 32'h3);
    cfg_write(0, 7, 32'h3);
    wait_stream();
    check_stream(3 * PASS, -1, -1, 1'b1, 3 * LL + K * IDX_SEGS + 2, 32'h0123ABCD);
  endtask

  task automatic test_drain();
    check_stream(PASS, 100, -1, 1'b1, -1, 32'h0);
    n_cmp++;
    if ({fpga_rst, si, frame_done, busy} !== 7'b1_0000_0_0) begin
      n_bad++;
      $display("FAIL drain_idle got rst=%b si=%h fd=%b busy=%b exp 1/0/0/0", fpga_rst, si, frame_done, busy);
    end
  endtask

  task automatic test_drain_resume();
    wait_stream();
    check_stream(2 * PASS, 200, 500, 1'b1, -1, 32'h0);
  endtask

  task automatic test_rst_abort();
    check_stream(K * IDX_SEGS + 3, -1, -1, 1'b0, -1, 32'h0);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fpga_rst, si, frame_done, busy} !== 7'b1_0000_0_0) begin
      n_bad++;
      $display("FAIL rst_abort got rst=%b si=%h fd=%b busy=%b exp 1/0/0/0", fpga_rst, si, frame_done, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    wait_stream();
    check_stream(PASS, 5, -1, 1'b0, -1, 32'h0);
    n_cmp++;
    if ({fpga_rst, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_pass_idle got rst=%b busy=%b exp 1/0", fpga_rst, busy);
    end
  endtask

  task automatic test_run_drop_in_reset();
    run = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, fpga_rst} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_entry got busy=%b rst=%b exp 1/1", busy, fpga_rst);
    end
    repeat (8) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, fpga_rst} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_abort got busy=%b rst=%b exp 0/1", busy, fpga_rst);
    end
  endtask

  // receiver deserializes each pass, then updates every LUT from the previous pass's outputs
  task automatic test_receiver();
    logic [31:0] acc;
    cfg_write(0, K, 32'h00000001);
    for (int k = 1; k < K; k++) cfg_write(1, k, 32'h1);
    cfg_write(1, K, 32'h40000002);
    for (int i = 0; i < N; i++) v[i] = 1'b0;
    acc = '0;
    wait_stream();
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < PASS; c++) begin
        int l, f, s, last;
        decode(c, l, f, s, last);
        acc = (s == 0 ? 32'h0 : acc << 4) | 32'(si);
        if (s == last) rx[l][f] = acc;
        @(negedge clk);
      end
      for (int i = 0; i < N; i++) begin
        int a;
        a = 0;
        for (int k = 0; k < K; k++)
          if (rx[i][k] < N && v[rx[i][k]]) a |= 1 << k;
        nv[i] = rx[i][K][a];
      end
      v = nv;
      n_cmp++;
      if ({v[1], v[0]} !== 2'(p + 1)) begin
        n_bad++;
        $display("FAIL rx_counter pass=%0d got %0d exp %0d", p, {v[1], v[0]}, 2'(p + 1));
      end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_drain();
    test_drain_resume();
    test_rst_abort();
    test_run_drop_in_reset();
    test_receiver();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
